// File: rtl/arm_mainfsm.sv
// Main control FSM for the multicycle ARM core: sequences fetch, decode, memory,
// execute, writeback and branch over the shared memory port, ALU and result bus.
module arm_mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Undef,
  output logic [3:0] State
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OUT_W   = 11;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    UNDEF  = 4'd10
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [OUT_W-1:0]   outs_q;

  // Only I and S/L are needed for sequencing; the rest of Funct belongs to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // Moore output table, packed as {AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, RegW, MemW, Branch, Undef}.
  function automatic logic [OUT_W-1:0] decode_outs(input state_t s);
    logic [OUT_W-1:0] o;
    o = '0;
    case (s)
      FETCH:   o = {1'b0, 1'b1, 2'b10, 1'b0, 2'b10, 4'b0000};
      DECODE:  o = {1'b0, 1'b1, 2'b10, 1'b0, 2'b10, 4'b0000};
      MEMADR:  o = {1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 4'b0000};
      MEMRD:   o = {1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000};
      MEMWB:   o = {1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b1000};
      MEMWR:   o = {1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0100};
      EXECR:   o = {1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 4'b0000};
      EXECI:   o = {1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 4'b0000};
      ALUWB:   o = {1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b1000};
      BRANCH:  o = {1'b0, 1'b0, 2'b01, 1'b0, 2'b10, 4'b0010};
      UNDEF:   o = {1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0001};
      default: o = '0;
    endcase
    return o;
  endfunction

  // Next-state logic; illegal codes fall back to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          default: state_d = UNDEF;
        endcase
      end
      MEMADR:  state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:   state_d = MemReady ? MEMWB : MEMRD;
      MEMWR:   state_d = MemReady ? FETCH : MEMWR;
      EXECR:   state_d = ALUWB;
      EXECI:   state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are registered from the next state so they always match State.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      outs_q  <= decode_outs(FETCH);
    end else begin
      state_q <= state_d;
      outs_q  <= decode_outs(state_d);
    end
  end

  assign {AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, RegW, MemW, Branch, Undef} = outs_q;
  assign State = state_q;

  // Instruction register and PC load only on the cycle the fetch completes.
  assign IRWrite = (state_q == FETCH) && MemReady;
  assign NextPC  = (state_q == FETCH) && MemReady;

endmodule

// File: tb/tb_arm_mainfsm.sv
// Directed self-checking bench for arm_mainfsm: per-cycle State and output
// checks against a hand-written table for each instruction class and stall.
module tb_arm_mainfsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, Undef;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  arm_mainfsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .Undef(Undef), .State(State)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, RegW, MemW, Branch, Undef}.
  function automatic logic [12:0] exp_outs(input int st, input logic rdy);
    case (st)
      0:  return {rdy, rdy, 1'b0, 1'b1, 2'b10, 1'b0, 2'b10, 4'b0000};
      1:  return {2'b00,    1'b0, 1'b1, 2'b10, 1'b0, 2'b10, 4'b0000};
      2:  return {2'b00,    1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 4'b0000};
      3:  return {2'b00,    1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000};
      4:  return {2'b00,    1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b1000};
      5:  return {2'b00,    1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0100};
      6:  return {2'b00,    1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 4'b0000};
      7:  return {2'b00,    1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 4'b0000};
      8:  return {2'b00,    1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b1000};
      9:  return {2'b00,    1'b0, 1'b0, 2'b01, 1'b0, 2'b10, 4'b0010};
      10: return {2'b00,    1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0001};
      default: return '0;
    endcase
  endfunction

  function automatic logic [12:0] obs_outs();
    return {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, RegW, MemW, Branch, Undef};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk one instruction from FETCH, applying MemReady per cycle and checking every cycle.
  task automatic run_seq(input string tag, input logic [1:0] op, input logic [5:0] f,
                         input int n, input int st[10], input logic rdy[10]);
    Op    = op;
    Funct = f;
    for (int i = 0; i < n; i++) begin
      MemReady = rdy[i];
      #1;
      check($sformatf("%s state[%0d]", tag, i), 32'(State), 32'(st[i]));
      check($sformatf("%s outs[%0d]", tag, i), 32'(obs_outs()), 32'(exp_outs(st[i], rdy[i])));
      tick();
    end
  endtask

  initial begin
    reset    = 1'b1;
    Op       = 2'b00;
    Funct    = 6'b000000;
    MemReady = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset state", 32'(State), 32'd0);
    check("reset outs", 32'(obs_outs()), 32'(exp_outs(0, 1'b0)));

    run_seq("add", 2'b00, 6'b000000, 4, '{0, 1, 6, 8, 0, 0, 0, 0, 0, 0},
            '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0});
    run_seq("imm", 2'b00, 6'b100001, 4, '{0, 1, 7, 8, 0, 0, 0, 0, 0, 0},
            '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0});
    run_seq("load", 2'b01, 6'b011001, 7, '{0, 1, 2, 3, 3, 3, 4, 0, 0, 0},
            '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0});
    run_seq("store", 2'b01, 6'b011000, 4, '{0, 1, 2, 5, 0, 0, 0, 0, 0, 0},
            '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0});
    run_seq("branch", 2'b10, 6'b000000, 3, '{0, 1, 9, 0, 0, 0, 0, 0, 0, 0},
            '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0});
    run_seq("undef", 2'b11, 6'b000000, 3, '{0, 1, 10, 0, 0, 0, 0, 0, 0, 0},
            '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0});
    run_seq("fstall", 2'b00, 6'b000000, 7, '{0, 0, 0, 0, 1, 6, 8, 0, 0, 0},
            '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0});

    // Park a store in MEMWR, then reset out of it.
    run_seq("rststore", 2'b01, 6'b011000, 5, '{0, 1, 2, 5, 5, 0, 0, 0, 0, 0},
            '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0});
    MemReady = 1'b0;
    #1;
    check("wait state", 32'(State), 32'd5);
    check("wait memw", 32'(MemW), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst state", 32'(State), 32'd0);
    check("midrst memw", 32'(MemW), 32'd0);
    check("midrst irwrite", 32'(IRWrite), 32'd0);
    check("midrst outs", 32'(obs_outs()), 32'(exp_outs(0, 1'b0)));
    MemReady = 1'b1;
    #1;
    check("midrst irwrite rdy", 32'(IRWrite), 32'd1);
    check("midrst nextpc rdy", 32'(NextPC), 32'd1);
    Op = 2'b10;
    tick();
    check("post state", 32'(State), 32'd1);
    check("post irwrite", 32'(IRWrite), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_mainfsm.md
# arm_mainfsm

Main control state machine for the multicycle build of the 32-bit ARM core. It decodes Op/Funct, then sequences fetch, decode, address generation, memory access, ALU execute, writeback and branch through shared datapath resources: one memory port, one ALU, one result bus. Its unconditional RegW, MemW and Branch requests feed the conditional-execution logic, which gates them with CondEx. A MemReady handshake stretches any memory-access state until the memory accepts or returns data.

## Interface
Parameters:
- none. Encodings are fixed by this spec.

Ports:
- clk  in  1  system clock. Everything updates on the rising edge.
- reset  in  1  synchronous, active-high. It is sampled on the rising edge of clk.
- Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  in  6  instruction bits [25:20]:
  - Funct[5] = I (immediate operand).
  - Funct[0] = S for data-processing, L for memory (1 = load).
- MemReady  in  1  memory handshake: the access completes in any cycle where this is 1.
- IRWrite  out  1  load the instruction register.
- NextPC  out  1  write PC+4 into PC.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
- ALUSrcA  out  1  ALU A select: 0 = register A, 1 = PC.
- ALUSrcB  out  2  ALU B select: 00 = register, 01 = extended immediate, 10 = constant 4.
- ALUOp  out  1  0 = add, 1 = decode operation from Funct.
- ResultSrc  out  2  result bus select: 00 = ALU out register, 01 = read data, 10 = ALU result.
- RegW  out  1  unconditional register-write request.
- MemW  out  1  unconditional memory-write request.
- Branch  out  1  unconditional branch request.
- Undef  out  1  undefined-instruction pulse.
- State  out  4  current state, for debug and the verification bench.

## Operation
State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNDEF=10
- Codes 11–15 are illegal and go to FETCH on the next edge.

Transitions:
- FETCH → DECODE when MemReady=1; otherwise stay in FETCH.
- DECODE → depends on Op:
  - Op=01 → MEMADR
  - Op=10 → BRANCH
  - Op=00 with Funct[5]=1 → EXECI
  - Op=00 with Funct[5]=0 → EXECR
  - Op=11 → UNDEF
- MEMADR → MEMRD if Funct[0]=1, else MEMWR.
- MEMRD → MEMWB when MemReady=1; otherwise stay.
- MEMWR → FETCH when MemReady=1; otherwise stay.
- EXECR and EXECI → ALUWB.
- MEMWB, ALUWB, BRANCH and UNDEF → FETCH.

Outputs:
- All outputs are Moore, decoded from State, except IRWrite and NextPC.
- Any output not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10. IRWrite = NextPC = MemReady.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
- MEMRD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, ResultSrc=00. MemW=1 in every cycle of the state; memory commits on the MemReady=1 cycle.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
- UNDEF: Undef=1 for exactly one cycle.

## Timing
- Reset: on a rising edge with reset=1, State becomes FETCH.
  - After reset, all outputs hold the FETCH values.
  - IRWrite and NextPC follow MemReady.
  - Reset overrides any in-progress state, including a MEMWR wait.
- Op and Funct are sampled only in DECODE and MEMADR. The instruction register holds them stable from the FETCH completion onward.
- Minimum latency in cycles, with MemReady=1 throughout:
  - Data-processing: 4 (FETCH, DECODE, EXEC*, ALUWB).
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - Undefined: 3.
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
  - While stalled, every output except IRWrite and NextPC is held constant.
- IRWrite and NextPC are never asserted outside FETCH. In FETCH they are asserted only in the single completing cycle.
- At most one of RegW, MemW and Branch is 1 in any cycle.

## Test plan
- Reset mid-operation:
  - Stimulus: drive a store with MemReady=0 so the FSM waits in MEMWR; assert reset for 1 cycle.
  - Response: State=0 on the next edge and MemW=0. With MemReady=0, IRWrite=0; then MemReady=1 gives IRWrite=1 and NextPC=1.
- Register ADD:
  - Stimulus: Op=00, Funct=000000, MemReady=1.
  - Response: State sequence 0,1,6,8,0. RegW=1 only in state 8. ALUOp=1 and ALUSrcB=00 in state 6.
- Immediate data-processing:
  - Stimulus: Op=00, Funct=100001.
  - Response: State sequence 0,1,7,8,0. ALUSrcB=01 in state 7.
- Load with a 2-cycle wait:
  - Stimulus: Op=01, Funct=011001; MemReady=0 for the first 2 cycles of MEMRD.
  - Response: State sequence 0,1,2,3,3,3,4,0. AdrSrc=1 throughout state 3. ResultSrc=01 and RegW=1 in state 4.
- Store and branch:
  - Stimulus: store with Op=01, Funct=011000; then branch with Op=10.
  - Response: store gives 0,1,2,5,0 with MemW=1 only in state 5. Branch gives 0,1,9,0 with Branch=1 and ALUSrcB=01 in state 9.
- Undefined instruction and FETCH stall:
  - Stimulus: Op=11; separately, MemReady=0 for 3 cycles in FETCH.
  - Response: Op=11 gives State 0,1,10,0 with Undef=1 for exactly 1 cycle. The FETCH stall holds State=0 with IRWrite=0, then IRWrite=1 for exactly 1 cycle.
